gray_ptr_fifo_ctrl: RTL
=======================

// Module: gray_ptr_fifo_ctrl
// PURPOSE
//  Single-clock FIFO with gray-coded read/write pointers. The gray pointers are
//  exported so a later dual-clock variant can synchronise them unchanged.
//  Pointers are decoded to binary with g2b instances, one per pointer.
//  Flags and the level count are derived from the decoded binary values.
//  Sits between a streaming producer and consumer as the sequencing/credit stage.
// PARAMETERS
//  DATA_WIDTH   8   payload width in bits
//  ADDR_WIDTH   4   log2(depth); depth = 2**ADDR_WIDTH, ADDR_WIDTH >= 2
//  AFULL_LVL    12  almost_full asserts when level >= AFULL_LVL (1..depth)
// PORTS
//  clk          in   1             rising-edge clock
//  rst          in   1             synchronous active-high reset
//  wr_valid     in   1             producer offers wr_data
//  wr_ready     out  1             FIFO accepts; push = wr_valid & wr_ready
//  wr_data      in   DATA_WIDTH    write payload
//  rd_valid     out  1             rd_data holds head entry
//  rd_ready     in   1             consumer takes head; pop = rd_valid & rd_ready
//  rd_data      out  DATA_WIDTH    head entry (first-word-fall-through)
//  level        out  ADDR_WIDTH+1  entries stored, 0..depth
//  almost_full  out  1             level >= AFULL_LVL
//  wr_ptr_gray  out  ADDR_WIDTH+1  write pointer, gray coded
//  rd_ptr_gray  out  ADDR_WIDTH+1  read pointer, gray coded
// BEHAVIOUR
//  - Pointers are PTR_W = ADDR_WIDTH+1 bits, held as gray registers.
//    Binary forms wr_bin and rd_bin come from g2b (DATA_WIDTH=PTR_W).
//  - Push: mem[wr_bin[ADDR_WIDTH-1:0]] <= wr_data.
//    Next wr_ptr_gray = bin2gray(wr_bin+1), mod 2**PTR_W. Exactly one bit toggles.
//  - Pop: next rd_ptr_gray = bin2gray(rd_bin+1), mod 2**PTR_W.
//  - empty: wr_ptr_gray == rd_ptr_gray.
//  - full: wr_ptr_gray == {~rd_ptr_gray[PTR_W-1:PTR_W-2], rd_ptr_gray[PTR_W-3:0]}.
//  - wr_ready = ~full; rd_valid = ~empty. Both are combinational from the pointer registers only.
//    Neither depends on same-cycle wr_valid or rd_ready.
//  - rd_data = mem[rd_bin[ADDR_WIDTH-1:0]], combinational read.
//    A pushed word is visible on rd_data the cycle after its push; latency is 1.
//  - level = (wr_bin - rd_bin) mod 2**PTR_W, combinational.
//    It updates the cycle after a push or pop.
//  - Simultaneous push and pop, when neither full nor empty: both pointers advance and level is unchanged.
//  - When full: wr_ready=0 and wr_valid is ignored; a pop is allowed. level becomes depth-1 the next cycle.
//  - When empty: rd_valid=0 and rd_ready is ignored; a push is allowed. There is no bypass, so rd_valid rises the next cycle.
//  - Wrap-around: pointers roll from binary 2**PTR_W-1 to 0. Flags and level stay correct across the wrap.
//  - Reset, including mid-operation: both pointers go to 0 on the next edge and stored data is discarded.
//    Reset values: wr_ready=1, rd_valid=0, level=0, almost_full=0, wr_ptr_gray=0, rd_ptr_gray=0.
//    mem contents are not reset; rd_data is don't-care while rd_valid=0.
//  - rst has priority over push and pop in the same cycle.
//  - States: EMPTY (level=0), PARTIAL, FULL (level=depth). These are implied by the pointers; no separate FSM register exists.
// TESTING
//  1. Reset, then idle -> rd_valid=0, wr_ready=1, level=0, both gray pointers 0.
//  2. Push 0x01..0x10 with no pop (depth 16) -> wr_ready falls after the 16th push and level=16.
//     almost_full rises when level reaches 12. wr_ptr_gray=5'b11000.
//  3. From full, pop all 16 -> rd_data is 0x01..0x10 in order, then rd_valid=0 and level=0.
//  4. Push and pop every cycle for 40 cycles starting at level 3 -> level stays 3, the data order is preserved,
//     and the pointers wrap past binary 31 with no flag glitch.
//  5. Each pointer update -> exactly one bit of the gray pointer changes. Assert this on every push and pop.
//  6. Fill to 7, then assert rst for one cycle while wr_valid=rd_ready=1 -> next cycle level=0, rd_valid=0,
//     and both pointers are 0. The first push after reset reads back correctly.

Source files
------------

// File: rtl/gray_ptr_fifo_ctrl.sv
// Single-clock FIFO with gray-coded read/write pointers and first-word-fall-through read.
// The gray pointers are exported unchanged so a dual-clock variant can synchronise them.

module g2b #(
    parameter int unsigned DATA_WIDTH = 5
) (
    input  logic [DATA_WIDTH-1:0] gray,
    output logic [DATA_WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

module gray_ptr_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AFULL_LVL  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PTR_W-1:0] AFULL_L = PTR_W'(AFULL_LVL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_bin, rd_bin;
    logic [PTR_W-1:0] wr_bin_inc, rd_bin_inc;
    logic             full, empty, push, pop;

    g2b #(
        .DATA_WIDTH(PTR_W)
    ) u_g2b_wr (
        .gray(wr_ptr_q),
        .bin (wr_bin)
    );

    g2b #(
        .DATA_WIDTH(PTR_W)
    ) u_g2b_rd (
        .gray(rd_ptr_q),
        .bin (rd_bin)
    );

    always_comb begin
        // Full when the pointers differ only in the wrap bit (top two bits in gray form).
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q == {~rd_ptr_q[PTR_W-1:PTR_W-2], rd_ptr_q[PTR_W-3:0]});
        wr_ready   = ~full;
        rd_valid   = ~empty;
        push       = wr_valid & ~full;
        pop        = rd_ready & ~empty;
        wr_bin_inc = wr_bin + PTR_W'(1);
        rd_bin_inc = rd_bin + PTR_W'(1);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_bin_inc ^ (wr_bin_inc >> 1);
        end
        if (pop) begin
            rd_ptr_d = rd_bin_inc ^ (rd_bin_inc >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset; rd_data is only meaningful while rd_valid is high.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_bin[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    always_comb begin
        rd_data     = mem_q[rd_bin[ADDR_WIDTH-1:0]];
        level       = wr_bin - rd_bin;
        almost_full = (level >= AFULL_L);
        wr_ptr_gray = wr_ptr_q;
        rd_ptr_gray = rd_ptr_q;
    end

endmodule
